adc_init_seq: RTL and testbench
===============================

ADC_INIT_SEQ -- requirements
Module: adc_init_seq

Interface
REQ-001 Parameter NUM_ENTRIES, default 16: number of (addr,data) writes in the init table, range 1..64.
REQ-002 Parameter WR_HOLD, default 64: cycles spi_wr is held high per write; must exceed the master's write transaction length of 50 clk.
REQ-003 Parameter GAP, default 4: cycles spi_wr and spi_rd are held low between transactions, minimum 2.
REQ-004 Parameter RD_TIMEOUT, default 255: maximum cycles to wait for spi_rdy during a readback.
REQ-005 clk  in  1  system clock; every flop updates on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  level; sampled only in IDLE; a high sample begins the sequence.
REQ-008 busy  out  1  high in every state except IDLE, DONE and ERR.
REQ-009 done  out  1  high while in DONE.
REQ-010 err  out  1  high while in ERR.
REQ-011 err_idx  out  6  table index of the failing entry; valid while err=1.
REQ-012 spi_addr  out  13  address to the SPI master, stable while spi_wr or spi_rd is high.
REQ-013 spi_data_tx  out  8  write data to the SPI master.
REQ-014 spi_wr  out  1  write request, multi-cycle level.
REQ-015 spi_rd  out  1  read request, multi-cycle level.
REQ-016 spi_data_rx  in  8  read data from the SPI master.
REQ-017 spi_rdy  in  1  one-cycle pulse; spi_data_rx is valid in the same cycle.

Function
REQ-018 FSM states: IDLE, LOAD, WRITE, WGAP, READ, RGAP, DONE, ERR.
REQ-019 IDLE -> LOAD when start=1; idx <= 0.
REQ-020 LOAD, 1 cycle: {spi_addr, spi_data_tx} <= rom[idx]; next state WRITE.
REQ-021 WRITE: spi_wr=1 for exactly WR_HOLD cycles, counted by a hold counter; then WGAP.
REQ-022 WGAP: spi_wr=0 and spi_rd=0 for GAP cycles, then:
  - verify enabled: go to READ;
  - verify disabled and idx=NUM_ENTRIES-1: go to DONE;
  - otherwise: idx <= idx+1 and go to LOAD.
REQ-023 READ: spi_rd=1 and spi_addr unchanged until spi_rdy=1 or the wait counter reaches RD_TIMEOUT.
  - spi_rdy with spi_data_rx equal to spi_data_tx: go to RGAP.
  - spi_rdy with mismatch, or timeout: go to ERR and set err_idx <= idx.
REQ-024 RGAP: GAP cycles with spi_rd=0; then DONE if idx=NUM_ENTRIES-1, else idx <= idx+1 and go to LOAD.
REQ-025 spi_wr and spi_rd are never high in the same cycle.
REQ-026 Every rising edge of spi_wr or spi_rd is preceded by at least GAP low cycles, so the master is guaranteed to have returned to idle.
REQ-027 DONE and ERR hold until start=0, then go to IDLE.
REQ-028 start=1 while busy is ignored.
REQ-029 start held high through DONE is not a restart; a new run requires start to return low and then high again.
REQ-030 Hold and wait counters are 8 bits wide; they reset to 0 on every state entry.
REQ-031 idx increments only in WGAP/RGAP; it never wraps past NUM_ENTRIES-1.
REQ-032 A spi_rdy pulse arriving outside READ is ignored.

Reset
REQ-033 rst=1 forces state=IDLE, idx=0, counters=0, spi_wr=0, spi_rd=0, spi_addr=0, spi_data_tx=0, err_idx=0.
REQ-034 rst=1 mid-transaction drops spi_wr and spi_rd on the next edge.
REQ-035 After reset, the first request edge is held off for GAP cycles, even if start is already high.

Configuration
REQ-036 Macro ADC_INIT_VERIFY_EN.
  - Defined: READ and RGAP, the compare logic and the timeout counter are compiled in, and err/err_idx are functional.
  - Undefined: those states and that logic are absent, spi_rd is tied to 0, and err/err_idx are tied to 0.

Structure
REQ-037 Shared package adc_spi_pkg holds:
  - the state enum;
  - SPI_ADDR_W=13 and SPI_DATA_W=8;
  - a struct {addr[12:0], data[7:0]} for table entries.
REQ-038 Sub-module adc_init_rom: combinational, index in, table entry out, contents fixed per ADC part.

Verification
REQ-039 NUM_ENTRIES=2, slave model; start pulse -> two spi_wr windows of exactly 64 cycles each with 4 low cycles between them, then done=1.
REQ-040 VERIFY_EN, slave echoes the written data -> each write is followed by spi_rd until spi_rdy, and the run ends with done=1, err=0.
REQ-041 VERIFY_EN, slave returns 0x00 for entry 1 where 0x5A was written -> err=1, err_idx=1, no further writes.
REQ-042 VERIFY_EN, slave never pulses spi_rdy -> after 255 cycles of spi_rd, err=1, spi_rd=0.
REQ-043 rst asserted at write cycle 30 -> spi_wr=0 on the next edge, state=IDLE, and no new request for at least 4 cycles after rst falls.
REQ-044 start toggled while busy, and start held high in DONE -> no restart in either case; a new run starts only after start falls and rises again.

Source files
------------

// File: rtl/adc_spi_pkg.sv
// Shared types for the ADC init sequencer: FSM state encoding, SPI field widths
// and the (addr,data) table entry.
package adc_spi_pkg;

    localparam int SPI_ADDR_W = 13;
    localparam int SPI_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_WGAP,
        ST_READ,
        ST_RGAP,
        ST_DONE,
        ST_ERR
    } adc_state_e;

    typedef struct packed {
        logic [SPI_ADDR_W-1:0] addr;
        logic [SPI_DATA_W-1:0] data;
    } rom_entry_t;

endpackage

// File: rtl/adc_init_seq_if.sv
// Request/response bundle between the init sequencer (master side) and the SPI
// master block (slave side).
interface adc_init_seq_if;
    import adc_spi_pkg::*;

    // spi_wr/spi_rd are level requests held for a whole transaction, with
    // spi_addr/spi_data_tx stable meanwhile; a read completes with a one-cycle
    // spi_rdy pulse carrying spi_data_rx. There is no backpressure.
    logic [SPI_ADDR_W-1:0] spi_addr;
    logic [SPI_DATA_W-1:0] spi_data_tx;
    logic                  spi_wr;
    logic                  spi_rd;
    logic [SPI_DATA_W-1:0] spi_data_rx;
    logic                  spi_rdy;

    modport master (
        output spi_addr, spi_data_tx, spi_wr, spi_rd,
        input  spi_data_rx, spi_rdy
    );

    modport slave (
        input  spi_addr, spi_data_tx, spi_wr, spi_rd,
        output spi_data_rx, spi_rdy
    );

endinterface

// File: rtl/adc_init_rom.sv
// Fixed register initialisation table for the target ADC part; combinational
// lookup, unused indices read as address 0 / data 0.
module adc_init_rom
    import adc_spi_pkg::*;
(
    input  logic [5:0] idx,
    output rom_entry_t entry
);

    always_comb begin
        entry = '0;
        case (idx)
            6'd0:  entry = {13'h0000, 8'h3C};
            6'd1:  entry = {13'h0014, 8'h5A};
            6'd2:  entry = {13'h0015, 8'h01};
            6'd3:  entry = {13'h0018, 8'h20};
            6'd4:  entry = {13'h0020, 8'h0F};
            6'd5:  entry = {13'h0021, 8'h81};
            6'd6:  entry = {13'h0022, 8'hC3};
            6'd7:  entry = {13'h0100, 8'h07};
            6'd8:  entry = {13'h0101, 8'h44};
            6'd9:  entry = {13'h0102, 8'hA5};
            6'd10: entry = {13'h0109, 8'h12};
            6'd11: entry = {13'h010B, 8'h66};
            6'd12: entry = {13'h0110, 8'h99};
            6'd13: entry = {13'h0120, 8'h02};
            6'd14: entry = {13'h1F00, 8'hE1};
            6'd15: entry = {13'h00FF, 8'h01};
            default: entry = '0;
        endcase
    end

endmodule

// File: rtl/adc_init_seq.sv
// ADC init sequencer: writes each table entry through the SPI master with a
// fixed hold window and idle gap. Define ADC_INIT_VERIFY_EN for readback compare.
module adc_init_seq
    import adc_spi_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter int WR_HOLD     = 64,
    parameter int GAP         = 4,
    parameter int RD_TIMEOUT  = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [5:0]            err_idx,
    output adc_state_e            dbg_state,
    adc_init_seq_if.master        spi
);

    localparam logic [5:0] LAST_IDX      = 6'(NUM_ENTRIES - 1);
    localparam logic [7:0] HOLD_LAST     = 8'(WR_HOLD - 1);
    localparam logic [7:0] GAP_LAST      = 8'(GAP - 1);
    // LOAD is itself a low cycle, so a gap that ends in LOAD is one cycle shorter.
    localparam logic [7:0] GAP_LOAD_LAST = 8'(GAP - 2);
    localparam logic [7:0] IDLE_HOLDOFF  = 8'(GAP - 1);

    adc_state_e state;
    logic [5:0] idx;
    logic [7:0] cnt;
    rom_entry_t entry;
    logic       is_last;
    logic [7:0] gap_end;

    adc_init_rom u_rom (
        .idx   (idx),
        .entry (entry)
    );

    assign is_last   = (idx == LAST_IDX);
    assign gap_end   = is_last ? GAP_LAST : GAP_LOAD_LAST;
    assign dbg_state = state;
    assign busy      = (state != ST_IDLE) && (state != ST_DONE) && (state != ST_ERR);
    assign done      = (state == ST_DONE);

`ifdef ADC_INIT_VERIFY_EN
    localparam logic [7:0] RD_LAST = 8'(RD_TIMEOUT - 1);
    logic       rd_q;
    logic [5:0] err_idx_q;
    assign spi.spi_rd = rd_q;
    assign err        = (state == ST_ERR);
    assign err_idx    = err_idx_q;
`else
    logic [16:0] unused_cfg;
    assign unused_cfg = {spi.spi_data_rx, spi.spi_rdy, 8'(RD_TIMEOUT)};
    assign spi.spi_rd = 1'b0;
    assign err        = 1'b0;
    assign err_idx    = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            idx             <= '0;
            cnt             <= '0;
            spi.spi_wr      <= 1'b0;
            spi.spi_addr    <= '0;
            spi.spi_data_tx <= '0;
`ifdef ADC_INIT_VERIFY_EN
            rd_q            <= 1'b0;
            err_idx_q       <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    // IDLE doubles as the post-reset/post-run hold-off before the next request.
                    if (start && (cnt >= IDLE_HOLDOFF)) begin
                        state <= ST_LOAD;
                        idx   <= '0;
                        cnt   <= '0;
                    end else if (cnt != 8'hFF) begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_LOAD: begin
                    spi.spi_addr    <= entry.addr;
                    spi.spi_data_tx <= entry.data;
                    spi.spi_wr      <= 1'b1;
                    cnt             <= '0;
                    state           <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (cnt == HOLD_LAST) begin
                        spi.spi_wr <= 1'b0;
                        cnt        <= '0;
                        state      <= ST_WGAP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
`ifdef ADC_INIT_VERIFY_EN
                ST_WGAP: begin
                    if (cnt == GAP_LAST) begin
                        rd_q  <= 1'b1;
                        cnt   <= '0;
                        state <= ST_READ;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_READ: begin
                    if (spi.spi_rdy) begin
                        rd_q <= 1'b0;
                        cnt  <= '0;
                        if (spi.spi_data_rx == spi.spi_data_tx) begin
                            state <= ST_RGAP;
                        end else begin
                            state     <= ST_ERR;
                            err_idx_q <= idx;
                        end
                    end else if (cnt == RD_LAST) begin
                        rd_q      <= 1'b0;
                        cnt       <= '0;
                        state     <= ST_ERR;
                        err_idx_q <= idx;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_RGAP,
`else
                ST_WGAP,
`endif
                ST_DONE, ST_ERR: begin
                    if (state == ST_DONE || state == ST_ERR) begin
                        if (!start) begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                        end
                    end else if (cnt == gap_end) begin
                        cnt <= '0;
                        if (is_last) begin
                            state <= ST_DONE;
                        end else begin
                            idx   <= idx + 6'd1;
                            state <= ST_LOAD;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_init_seq.sv
// Testbench for adc_init_seq: directed run sequence with randomized timing,
// slave model on the SPI side and a transaction-level reference model.
module tb_adc_init_seq;
  import adc_spi_pkg::*;

  localparam int N          = 2;
  localparam int WR_HOLD    = 64;
  localparam int GAP        = 4;
  localparam int RD_TIMEOUT = 255;
  localparam int EW         = SPI_ADDR_W + SPI_DATA_W;
  localparam int W          = 1 + EW;
  localparam int RUN_BUDGET = 3000;
  localparam int MODE_ECHO   = 0;
  localparam int MODE_BAD1   = 1;
  localparam int MODE_SILENT = 2;
`ifdef ADC_INIT_VERIFY_EN
  localparam bit VERIFY_EN = 1'b1;
`else
  localparam bit VERIFY_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy, done, err;
  logic [5:0] err_idx;
  adc_state_e dbg_state;

  adc_init_seq_if spi ();

  adc_init_seq #(
    .NUM_ENTRIES (N),
    .WR_HOLD     (WR_HOLD),
    .GAP         (GAP),
    .RD_TIMEOUT  (RD_TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_idx   (err_idx),
    .dbg_state (dbg_state),
    .spi       (spi)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input bit ok);
    checks++;
    if (!ok) begin
      failures++;
      $error("FAIL %s", tag);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [EW-1:0] part_entry(input int i);
    case (i)
      0:  return {13'h0000, 8'h3C};
      1:  return {13'h0014, 8'h5A};
      2:  return {13'h0015, 8'h01};
      3:  return {13'h0018, 8'h20};
      4:  return {13'h0020, 8'h0F};
      5:  return {13'h0021, 8'h81};
      6:  return {13'h0022, 8'hC3};
      7:  return {13'h0100, 8'h07};
      8:  return {13'h0101, 8'h44};
      9:  return {13'h0102, 8'hA5};
      10: return {13'h0109, 8'h12};
      11: return {13'h010B, 8'h66};
      12: return {13'h0110, 8'h99};
      13: return {13'h0120, 8'h02};
      14: return {13'h1F00, 8'hE1};
      15: return {13'h00FF, 8'h01};
      default: return '0;
    endcase
  endfunction

  logic [W-1:0] exp_q[$];
  bit           exp_done;
  bit           exp_err;
  logic [5:0]   exp_err_idx;

  // A run is: per entry a write, then (with readback) a read of the same entry;
  // a failed readback ends the run in error at that entry.
  function automatic void build_expected(input int mode);
    logic [EW-1:0] e;
    bit stop;
    exp_q.delete();
    exp_done    = 1'b1;
    exp_err     = 1'b0;
    exp_err_idx = '0;
    stop        = 1'b0;
    for (int i = 0; i < N && !stop; i++) begin
      e = part_entry(i);
      exp_q.push_back({1'b0, e});
      if (VERIFY_EN) begin
        exp_q.push_back({1'b1, e});
        if ((mode == MODE_BAD1 && i == 1) || mode == MODE_SILENT) begin
          exp_done    = 1'b0;
          exp_err     = 1'b1;
          exp_err_idx = 6'(i);
          stop        = 1'b1;
        end
      end
    end
  endfunction

  // ---------------- bus monitor ----------------
  logic [W-1:0] obs_q[$];
  int           obs_len_q[$];
  int           obs_gap_q[$];
  bit           in_win = 1'b0;
  logic [W-1:0] win_item;
  int           win_len;
  int           low_cnt = 0;
  bit           addr_moved;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      in_win  = 1'b0;
      low_cnt = 0;
    end else begin
      chk("wr_rd_exclusive", (spi.spi_wr & spi.spi_rd) === 1'b0);
      if (spi.spi_wr || spi.spi_rd) begin
        if (!in_win) begin
          chk("req_gap_min", low_cnt >= GAP);
          in_win     = 1'b1;
          win_item   = {spi.spi_rd, spi.spi_addr, spi.spi_data_tx};
          win_len    = 1;
          addr_moved = 1'b0;
          obs_gap_q.push_back(low_cnt);
        end else begin
          win_len++;
          if ({spi.spi_rd, spi.spi_addr} != win_item[W-1 -: 14]) addr_moved = 1'b1;
        end
      end else begin
        if (in_win) begin
          chk("addr_stable", addr_moved === 1'b0);
          obs_q.push_back(win_item);
          obs_len_q.push_back(win_len);
          in_win  = 1'b0;
          low_cnt = 0;
        end
        if (low_cnt < 100000) low_cnt++;
      end
    end
  end

  // ---------------- SPI slave model ----------------
  int slave_mode = MODE_ECHO;

  initial begin
    int lat;
    bit pending;
    logic [EW-1:0] bad_entry;
    bad_entry       = part_entry(1);
    pending         = 1'b0;
    lat             = 0;
    spi.spi_rdy     = 1'b0;
    spi.spi_data_rx = '0;
    forever begin
      @(negedge clk);
      spi.spi_rdy = 1'b0;
      if (rst || !spi.spi_rd) begin
        pending = 1'b0;
        // stray responses while no read is pending
        if (!rst && $urandom_range(0, 15) == 0) begin
          spi.spi_rdy     = 1'b1;
          spi.spi_data_rx = 8'($urandom);
        end
      end else begin
        if (!pending) begin
          pending = 1'b1;
          lat     = $urandom_range(0, 20);
        end
        if (lat == 0) begin
          if (slave_mode != MODE_SILENT) begin
            spi.spi_rdy = 1'b1;
            if (slave_mode == MODE_BAD1 && spi.spi_addr == bad_entry[EW-1 -: SPI_ADDR_W])
              spi.spi_data_rx = 8'h00;
            else
              spi.spi_data_rx = spi.spi_data_tx;
          end
        end else begin
          lat--;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_q.delete();
    obs_len_q.delete();
    obs_gap_q.delete();
  endtask

  task automatic wait_end(input string tag);
    bit ended;
    ended = 1'b0;
    for (int c = 0; c < RUN_BUDGET && !ended; c++) begin
      sample();
      ended = done | err;
    end
    chk(tag, ended === 1'b1);
    sample();
  endtask

  task automatic check_run(input int mode);
    logic [W-1:0] o, e;
    int len, gap, k;
    build_expected(mode);
    chk("txn_count", obs_q.size() == exp_q.size());
    k = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e   = exp_q.pop_front();
      o   = obs_q.pop_front();
      len = obs_len_q.pop_front();
      gap = obs_gap_q.pop_front();
      chk("txn_item", o === e);
      if (e[W-1] == 1'b0) chk("wr_len", len == WR_HOLD);
      else if (mode == MODE_SILENT) chk("rd_timeout_len", len == RD_TIMEOUT);
      if (k > 0) chk("req_gap_exact", gap == GAP);
      k++;
    end
    chk("end_done", done === exp_done);
    chk("end_err", err === exp_err);
    chk("end_err_idx", err_idx === exp_err_idx);
    chk("end_busy", busy === 1'b0);
    chk("end_wr_low", spi.spi_wr === 1'b0);
    chk("end_rd_low", spi.spi_rd === 1'b0);
    clear_obs();
  endtask

  task automatic release_start();
    @(negedge clk);
    start = 1'b0;
    sample();
    sample();
    chk("idle_after_release", dbg_state === ST_IDLE);
    chk("done_after_release", done === 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hold;
    bit found;
    rst   = 1'b1;
    start = 1'b0;
    tick(3);
    sample();
    chk("rst_busy", busy === 1'b0);
    chk("rst_done", done === 1'b0);
    chk("rst_err", err === 1'b0);
    chk("rst_err_idx", err_idx === 6'd0);
    chk("rst_wr", spi.spi_wr === 1'b0);
    chk("rst_rd", spi.spi_rd === 1'b0);
    chk("rst_addr", spi.spi_addr === 13'd0);
    chk("rst_data_tx", spi.spi_data_tx === 8'd0);
    chk("rst_state", dbg_state === ST_IDLE);

    // start already high while reset releases
    clear_obs();
    @(negedge clk);
    start = 1'b1;
    tick(2);
    rst = 1'b0;
    wait_end("run1_end");
    check_run(MODE_ECHO);

    // start held high in DONE must not restart
    hold = $urandom_range(10, 40);
    repeat (hold) sample();
    chk("done_held", done === 1'b1);
    chk("no_restart_in_done", obs_q.size() == 0);
    release_start();

    // start toggled while busy
    clear_obs();
    @(negedge clk);
    start = 1'b1;
    tick(GAP + 2);
    repeat (60) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    start = 1'b1;
    wait_end("toggle_run_end");
    check_run(MODE_ECHO);
    release_start();

    // reset in write cycle 30
    clear_obs();
    @(negedge clk);
    start = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      sample();
      found = spi.spi_wr;
    end
    chk("wr_seen_before_rst", found === 1'b1);
    repeat (29) sample();
    @(negedge clk);
    rst = 1'b1;
    sample();
    chk("rst_mid_wr_drop", spi.spi_wr === 1'b0);
    chk("rst_mid_state", dbg_state === ST_IDLE);
    chk("rst_mid_busy", busy === 1'b0);
    @(negedge clk);
    rst = 1'b0;
    clear_obs();
    for (int c = 0; c < GAP; c++) begin
      sample();
      chk("no_req_after_rst", (spi.spi_wr | spi.spi_rd) === 1'b0);
    end
    wait_end("post_rst_run_end");
    check_run(MODE_ECHO);
    release_start();

    // randomized start timing
    for (int r = 0; r < 3; r++) begin
      clear_obs();
      tick($urandom_range(0, 10));
      start = 1'b1;
      wait_end("rand_run_end");
      check_run(MODE_ECHO);
      release_start();
    end

`ifdef ADC_INIT_VERIFY_EN
    // readback mismatch on entry 1
    slave_mode = MODE_BAD1;
    clear_obs();
    @(negedge clk);
    start = 1'b1;
    wait_end("bad_run_end");
    check_run(MODE_BAD1);
    repeat (20) sample();
    chk("no_write_after_err", obs_q.size() == 0);
    chk("err_held", err === 1'b1);
    release_start();

    // slave never answers
    slave_mode = MODE_SILENT;
    clear_obs();
    @(negedge clk);
    start = 1'b1;
    wait_end("silent_run_end");
    check_run(MODE_SILENT);
    release_start();
    slave_mode = MODE_ECHO;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
